// File: rtl/lot_pkg.sv
// Shared encodings for the parking-lot occupancy counter: lane FSM states,
// filtered {a,b} sensor patterns and a small population-count helper.
package lot_pkg;

  typedef logic [2:0] lane_state_t;

  localparam lane_state_t ST_IDLE   = 3'd0;
  localparam lane_state_t ST_IN_A   = 3'd1;
  localparam lane_state_t ST_IN_AB  = 3'd2;
  localparam lane_state_t ST_IN_B   = 3'd3;
  localparam lane_state_t ST_OUT_B  = 3'd4;
  localparam lane_state_t ST_OUT_AB = 3'd5;
  localparam lane_state_t ST_OUT_A  = 3'd6;

  // Sensor patterns are written {a,b}: a is the outer sensor, b the inner one.
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_AB   = 2'b11;
  localparam logic [1:0] AB_B    = 2'b01;

  function automatic logic [3:0] count_ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/lot_occupancy_counter_if.sv
// Signal bundle between the sensor/display side (master) and the occupancy
// counter (slave), plus a per-lane FSM state debug bus.
interface lot_occupancy_counter_if #(
    parameter int NUM_LANES = 2,
    parameter int COUNT_W   = 14
);
    // No valid/ready handshake: sensors are level signals sampled every cycle,
    // clear is a single-cycle strobe, all outputs are registered levels/pulses.
    logic [NUM_LANES-1:0]   sensor_a;
    logic [NUM_LANES-1:0]   sensor_b;
    logic                   clear;
    logic [COUNT_W-1:0]     car_count;
    logic                   full;
    logic                   empty;
    logic [NUM_LANES-1:0]   seq_err;
    logic                   overflow;
    logic                   underflow;
    logic [3*NUM_LANES-1:0] lane_state;

    modport master (
        output sensor_a, sensor_b, clear,
        input  car_count, full, empty, seq_err, overflow, underflow, lane_state
    );

    modport slave (
        input  sensor_a, sensor_b, clear,
        output car_count, full, empty, seq_err, overflow, underflow, lane_state
    );

endinterface

// File: rtl/lane_tracker.sv
// One lane: two-flop synchronisers, per-input debounce filters and the
// direction-aware sequence FSM producing registered enter/leave/err pulses.
module lane_tracker
    import lot_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        raw_a,
    input  logic        raw_b,
    output logic        enter,
    output logic        leave,
    output logic        err,
    output lane_state_t state
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [1:0]    sync1, sync2, filt, prev;
    logic [CW-1:0] cnt [2];
    lane_state_t   state_q, state_d;
    logic          chg, legal, enter_d, leave_d, err_d;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {raw_a, raw_b};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            filt <= '0;
            for (int k = 0; k < 2; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == filt[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CW'(DEBOUNCE - 1)) begin
                    filt[k] <= sync2[k];
                    cnt[k]  <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    // The FSM only reacts to a change of the filtered pattern, so a pattern
    // still held after an illegal jump is not reported again every cycle.
    assign chg = (filt != prev);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            prev    <= AB_NONE;
            enter   <= 1'b0;
            leave   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            prev    <= filt;
            enter   <= enter_d;
            leave   <= leave_d;
            err     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (chg) begin
            case (state_q)
                ST_IDLE: case (filt)
                    AB_A:    state_d = ST_IN_A;
                    AB_B:    state_d = ST_OUT_B;
                    default: state_d = ST_IDLE;
                endcase
                ST_IN_A: case (filt)
                    AB_AB:   state_d = ST_IN_AB;
                    AB_A:    state_d = ST_IN_A;
                    default: state_d = ST_IDLE;
                endcase
                ST_IN_AB: case (filt)
                    AB_B:    state_d = ST_IN_B;
                    AB_A:    state_d = ST_IN_A;
                    AB_AB:   state_d = ST_IN_AB;
                    default: state_d = ST_IDLE;
                endcase
                ST_IN_B: case (filt)
                    AB_AB:   state_d = ST_IN_AB;
                    AB_B:    state_d = ST_IN_B;
                    default: state_d = ST_IDLE;
                endcase
                ST_OUT_B: case (filt)
                    AB_AB:   state_d = ST_OUT_AB;
                    AB_B:    state_d = ST_OUT_B;
                    default: state_d = ST_IDLE;
                endcase
                ST_OUT_AB: case (filt)
                    AB_A:    state_d = ST_OUT_A;
                    AB_B:    state_d = ST_OUT_B;
                    AB_AB:   state_d = ST_OUT_AB;
                    default: state_d = ST_IDLE;
                endcase
                ST_OUT_A: case (filt)
                    AB_AB:   state_d = ST_OUT_AB;
                    AB_A:    state_d = ST_OUT_A;
                    default: state_d = ST_IDLE;
                endcase
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Legal = stay, one step forward or one step back along the path.
    always_comb begin
        legal = 1'b1;
        case (state_q)
            ST_IDLE:   legal = filt inside {AB_NONE, AB_A, AB_B};
            ST_IN_A:   legal = filt inside {AB_A, AB_AB, AB_NONE};
            ST_IN_AB:  legal = filt inside {AB_AB, AB_B, AB_A};
            ST_IN_B:   legal = filt inside {AB_B, AB_NONE, AB_AB};
            ST_OUT_B:  legal = filt inside {AB_B, AB_AB, AB_NONE};
            ST_OUT_AB: legal = filt inside {AB_AB, AB_A, AB_B};
            ST_OUT_A:  legal = filt inside {AB_A, AB_NONE, AB_AB};
            default:   legal = 1'b1;
        endcase
        err_d   = chg && !legal;
        enter_d = chg && (state_q == ST_IN_B)  && (filt == AB_NONE);
        leave_d = chg && (state_q == ST_OUT_A) && (filt == AB_NONE);
    end

    assign state = state_q;

endmodule

// File: rtl/lot_occupancy_counter.sv
// Multi-lane occupancy counter: one lane_tracker per lane feeding a shared
// saturating count with registered full/empty and sticky over/underflow flags.
module lot_occupancy_counter
    import lot_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int COUNT_W   = 14,
    parameter int CAPACITY  = 9999,
    parameter int DEBOUNCE  = 4
) (
    input  logic clk,
    input  logic res_n,
    lot_occupancy_counter_if.slave bus
);

    localparam int SW = COUNT_W + 4;
    localparam logic [COUNT_W-1:0] CAP_V = COUNT_W'(CAPACITY);
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    logic [NUM_LANES-1:0] enter_v, leave_v, err_v;
    lane_state_t          st_v [NUM_LANES];
    logic [3:0]           n_enter, n_leave;
    logic signed [SW-1:0] sum;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 full_q, empty_q, ovf_q, unf_q, ovf_d, unf_d;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_tracker #(.DEBOUNCE(DEBOUNCE)) u_lane (
            .clk   (clk),
            .res_n (res_n),
            .raw_a (bus.sensor_a[g]),
            .raw_b (bus.sensor_b[g]),
            .enter (enter_v[g]),
            .leave (leave_v[g]),
            .err   (err_v[g]),
            .state (st_v[g])
        );
    end

    always_comb begin
        bus.lane_state = '0;
        for (int i = 0; i < NUM_LANES; i++) bus.lane_state[3*i +: 3] = st_v[i];
    end

    // Opposite events net out in the signed sum before any clamping.
    always_comb begin
        n_enter = count_ones8(8'(enter_v));
        n_leave = count_ones8(8'(leave_v));
        sum     = $signed(SW'(count_q)) + $signed(SW'(n_enter)) - $signed(SW'(n_leave));
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (sum[SW-1]) begin
            count_d = '0;
            unf_d   = 1'b1;
        end else if (sum > CAP_S) begin
            count_d = CAP_V;
            ovf_d   = 1'b1;
        end else begin
            count_d = sum[COUNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (bus.clear) begin
            count_q <= '0;
            full_q  <= (CAP_V == '0);
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CAP_V);
            empty_q <= (count_d == '0);
            ovf_q   <= ovf_q | ovf_d;
            unf_q   <= unf_q | unf_d;
        end
    end

    assign bus.car_count = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.seq_err   = err_v;

endmodule
